// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the cache fill FSMs.
package mem_pkg;

  localparam int unsigned WORD_W         = 16;
  localparam int unsigned LINE_WORDS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_e;

  // Owner of the most recent line fill, used to alternate on I/D ties.
  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } fill_owner_e;

  // Counter width that can hold 0..words without wrapping.
  function automatic int unsigned cnt_width(input int unsigned words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side requests, memory command/response and routed results.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              i_req;
  logic [WORD_W-1:0] i_addr;
  logic              d_req;
  logic [WORD_W-1:0] d_addr;
  logic              d_wrt;
  logic [WORD_W-1:0] d_wdata;
  logic [WORD_W-1:0] mem_data;
  logic              mem_data_vld;

  logic              mem_en;
  logic              mem_wr;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              i_grant;
  logic              d_grant;
  logic              i_data_vld;
  logic              d_data_vld;
  logic [WORD_W-1:0] rdata;
  logic              d_wr_done;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wrt, d_wdata, mem_data, mem_data_vld,
    output mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
           i_data_vld, d_data_vld, rdata, d_wr_done
  );

  // Caches and memory side.
  modport master (
    output i_req, i_addr, d_req, d_addr, d_wrt, d_wdata, mem_data, mem_data_vld,
    input  mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
           i_data_vld, d_data_vld, rdata, d_wr_done
  );

endinterface

// File: rtl/mem_arbiter_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_counter #(
  parameter int unsigned MAX = 8,
  parameter int unsigned W   = $clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up to MAX and hold there until cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt < W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single memory port between I-cache fills, D-cache fills and
// D-cache write-throughs. Read latency is not tracked; fills end on the
// LINE_WORDS-th returned beat.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned LINE_WORDS  = LINE_WORDS_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CW = cnt_width(LINE_WORDS);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be at least 1");
  end
  if (LINE_WORDS < 1) begin : g_bad_line
    $error("mem_arbiter: LINE_WORDS must be at least 1");
  end

  arb_state_e        state;
  fill_owner_e       last_owner;
  logic              i_grant_q;
  logic              d_grant_q;
  logic              wr_q;

  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     ret_cnt;
  logic              in_fill;
  logic              owner_req;
  logic [WORD_W-1:0] owner_addr;
  logic              rd_fwd;
  logic              beat;
  logic              last_beat;

  // Fill bookkeeping: which requester is served and whether a read goes out.
  always_comb begin
    in_fill    = (state == I_FILL) || (state == D_FILL);
    owner_req  = (state == I_FILL) ? bus.i_req  : bus.d_req;
    owner_addr = (state == I_FILL) ? bus.i_addr : bus.d_addr;
    rd_fwd     = in_fill && owner_req && (issue_cnt < CW'(LINE_WORDS));
    beat       = in_fill && bus.mem_data_vld;
    last_beat  = beat && (ret_cnt == CW'(LINE_WORDS - 1));
  end

  arb_counter #(.MAX(LINE_WORDS), .W(CW)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (last_beat),
    .inc (rd_fwd),
    .cnt (issue_cnt)
  );

  arb_counter #(.MAX(LINE_WORDS), .W(CW)) u_ret_cnt (
    .clk (clk),
    .rst (rst),
    .clr (last_beat),
    .inc (beat),
    .cnt (ret_cnt)
  );

  // Arbitration FSM with registered grant and write-strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWNER_I;
      i_grant_q  <= 1'b0;
      d_grant_q  <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_wrt) begin
            state     <= D_WRITE;
            d_grant_q <= 1'b1;
            wr_q      <= 1'b1;
          end else if (bus.d_req && (!bus.i_req || (last_owner == OWNER_I))) begin
            state      <= D_FILL;
            d_grant_q  <= 1'b1;
            last_owner <= OWNER_D;
          end else if (bus.i_req) begin
            state      <= I_FILL;
            i_grant_q  <= 1'b1;
            last_owner <= OWNER_I;
          end
        end
        D_WRITE: begin
          state     <= IDLE;
          d_grant_q <= 1'b0;
          wr_q      <= 1'b0;
        end
        I_FILL, D_FILL: begin
          if (last_beat) begin
            state     <= IDLE;
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          i_grant_q <= 1'b0;
          d_grant_q <= 1'b0;
          wr_q      <= 1'b0;
        end
      endcase
    end
  end

  // Memory command and routed response; returns outside a fill are dropped.
  always_comb begin
    bus.mem_en     = wr_q || rd_fwd;
    bus.mem_wr     = wr_q;
    bus.mem_addr   = wr_q ? bus.d_addr : (in_fill ? owner_addr : '0);
    bus.mem_wdata  = wr_q ? bus.d_wdata : '0;
    bus.i_grant    = i_grant_q;
    bus.d_grant    = d_grant_q;
    bus.i_data_vld = bus.mem_data_vld && (state == I_FILL);
    bus.d_data_vld = bus.mem_data_vld && (state == D_FILL);
    bus.rdata      = bus.mem_data;
    bus.d_wr_done  = wr_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic.
module tb_mem_arbiter;

  localparam int unsigned LAT = 4;
  localparam int unsigned LW  = 8;
  localparam int JOB_NONE = 0;
  localparam int JOB_I    = 1;
  localparam int JOB_D    = 2;
  localparam int JOB_W    = 3;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_LATENCY(LAT), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: who owns memory, words requested/returned in the current line.
  int job      = JOB_NONE;
  int issued   = 0;
  int returned = 0;
  bit last_d   = 1'b0;

  int cycle = 0;
  int mq[$];
  bit spurious = 1'b0;

  logic        o_mem_en, o_mem_wr, o_i_grant, o_d_grant, o_ivld, o_dvld, o_wr_done;
  logic [15:0] o_mem_addr, o_mem_wdata, last_rd_addr;
  int          cnt_rd, cnt_ivld, cnt_dvld;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick_winner(input bit wrt, input bit dreq, input bit ireq,
                                     input bit prev_d);
    if (wrt) return JOB_W;
    if (dreq && ireq) return prev_d ? JOB_I : JOB_D;
    if (dreq) return JOB_D;
    if (ireq) return JOB_I;
    return JOB_NONE;
  endfunction

  task automatic clear_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = 16'h0;
    bus.d_req   = 1'b0;
    bus.d_addr  = 16'h0;
    bus.d_wrt   = 1'b0;
    bus.d_wdata = 16'h0;
    spurious    = 1'b0;
  endtask

  task automatic reset_counts();
    cnt_rd   = 0;
    cnt_ivld = 0;
    cnt_dvld = 0;
  endtask

  // One clock: present memory response, compare, then advance the reference.
  task automatic step();
    logic        e_fill, e_req, e_en, e_wr;
    logic [15:0] e_addr, e_wdata;
    int          w;
    @(negedge clk);
    if (mq.size() > 0 && mq[0] == cycle) begin
      void'(mq.pop_front());
      bus.mem_data_vld = 1'b1;
    end else begin
      bus.mem_data_vld = spurious;
    end
    bus.mem_data = 16'($urandom);
    #1;
    e_fill  = (job == JOB_I) || (job == JOB_D);
    e_req   = (job == JOB_I) ? bus.i_req : bus.d_req;
    e_en    = (job == JOB_W) || (e_fill && e_req && (issued < int'(LW)));
    e_wr    = (job == JOB_W);
    e_addr  = (job == JOB_W || job == JOB_D) ? bus.d_addr :
              (job == JOB_I) ? bus.i_addr : 16'h0;
    e_wdata = e_wr ? bus.d_wdata : 16'h0;
    check_eq("mem_en", bus.mem_en, e_en);
    check_eq("mem_wr", bus.mem_wr, e_wr);
    check_eq("mem_addr", bus.mem_addr, e_addr);
    check_eq("mem_wdata", bus.mem_wdata, e_wdata);
    check_eq("i_grant", bus.i_grant, job == JOB_I);
    check_eq("d_grant", bus.d_grant, job == JOB_D || job == JOB_W);
    check_eq("i_data_vld", bus.i_data_vld, bus.mem_data_vld && job == JOB_I);
    check_eq("d_data_vld", bus.d_data_vld, bus.mem_data_vld && job == JOB_D);
    check_eq("d_wr_done", bus.d_wr_done, e_wr);
    check_eq("rdata", bus.rdata, bus.mem_data);
    check_eq("grant_overlap", bus.i_grant & bus.d_grant, 1'b0);
    o_mem_en    = bus.mem_en;
    o_mem_wr    = bus.mem_wr;
    o_mem_addr  = bus.mem_addr;
    o_mem_wdata = bus.mem_wdata;
    o_i_grant   = bus.i_grant;
    o_d_grant   = bus.d_grant;
    o_ivld      = bus.i_data_vld;
    o_dvld      = bus.d_data_vld;
    o_wr_done   = bus.d_wr_done;
    if (bus.mem_en && !bus.mem_wr) begin
      cnt_rd++;
      last_rd_addr = bus.mem_addr;
    end
    if (bus.i_data_vld) cnt_ivld++;
    if (bus.d_data_vld) cnt_dvld++;
    @(posedge clk);
    #1;
    if (e_en && !e_wr) mq.push_back(cycle + int'(LAT));
    if (rst) begin
      job = JOB_NONE; issued = 0; returned = 0; last_d = 1'b0;
    end else if (job == JOB_NONE) begin
      w = pick_winner(bus.d_wrt, bus.d_req, bus.i_req, last_d);
      if (w == JOB_I) last_d = 1'b0;
      if (w == JOB_D) last_d = 1'b1;
      job = w;
    end else if (job == JOB_W) begin
      job = JOB_NONE;
    end else begin
      if (e_en) issued++;
      if (bus.mem_data_vld) returned++;
      if (returned == int'(LW)) begin
        job = JOB_NONE; issued = 0; returned = 0;
      end
    end
    cycle++;
  endtask

  // Let outstanding reads return and any open fill finish.
  task automatic drain(input string tag);
    int g = 0;
    clear_inputs();
    while ((mq.size() > 0 || job != JOB_NONE) && g < 200) begin
      bus.i_req = (job == JOB_I);
      bus.d_req = (job == JOB_D);
      step();
      g++;
    end
    clear_inputs();
    step();
    check_eq(tag, g < 200, 1'b1);
  endtask

  initial begin
    int g, n, gap, first;
    int winners[2];
    clear_inputs();
    bus.mem_data     = 16'h0;
    bus.mem_data_vld = 1'b0;
    reset_counts();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_eq("reset_mem_en", o_mem_en, 1'b0);
    check_eq("reset_grants", {o_i_grant, o_d_grant}, 2'b00);

    // Simultaneous I/D fill requests, twice: D first, then I.
    for (int r = 0; r < 2; r++) begin
      clear_inputs();
      bus.i_req = 1'b1; bus.i_addr = 16'h0200;
      bus.d_req = 1'b1; bus.d_addr = 16'h0300;
      first = JOB_NONE;
      g = 0;
      do begin
        step();
        g++;
        if (first == JOB_NONE) first = o_d_grant ? JOB_D : (o_i_grant ? JOB_I : JOB_NONE);
      end while ((job != JOB_NONE || first == JOB_NONE) && g < 100);
      check_eq("tie_timeout", g < 100, 1'b1);
      winners[r] = first;
      clear_inputs();
      step();
    end
    check_eq("tie1_winner", winners[0], JOB_D);
    check_eq("tie2_winner", winners[1], JOB_I);
    drain("drain_tie");

    // Write-through from IDLE.
    clear_inputs();
    bus.d_wrt = 1'b1; bus.d_addr = 16'h0040; bus.d_wdata = 16'hBEEF;
    step();
    bus.d_wrt = 1'b0;
    step();
    check_eq("wr_mem_en", o_mem_en, 1'b1);
    check_eq("wr_mem_wr", o_mem_wr, 1'b1);
    check_eq("wr_mem_addr", o_mem_addr, 16'h0040);
    check_eq("wr_mem_wdata", o_mem_wdata, 16'hBEEF);
    check_eq("wr_done", o_wr_done, 1'b1);
    step();
    check_eq("wr_back_idle", {o_mem_en, o_d_grant, o_wr_done}, 3'b000);

    // I fill with request held 12 cycles, address stepping by 2 per read.
    clear_inputs();
    reset_counts();
    bus.i_req = 1'b1; bus.i_addr = 16'h0100;
    n = 0; g = 0;
    while ((job != JOB_NONE || n < 12) && g < 100) begin
      step();
      g++; n++;
      if (o_mem_en && !o_mem_wr) bus.i_addr = bus.i_addr + 16'd2;
      if (n == 12) bus.i_req = 1'b0;
    end
    check_eq("ifill_timeout", g < 100, 1'b1);
    check_eq("ifill_reads", cnt_rd, LW);
    check_eq("ifill_valids", cnt_ivld, LW);
    check_eq("ifill_last_addr", last_rd_addr, 16'h010E);
    step();
    check_eq("ifill_grant_drop", o_i_grant, 1'b0);

    // D request arriving during an I fill waits for the line plus one idle cycle.
    clear_inputs();
    bus.i_req = 1'b1; bus.i_addr = 16'h0400; bus.d_addr = 16'h0500;
    g = 0;
    do begin step(); g++; end while (!o_i_grant && g < 20);
    bus.d_req = 1'b1;
    reset_counts();
    n = 0;
    while (job != JOB_NONE && g < 100) begin
      step();
      g++; n++;
      if (n == 10) bus.i_req = 1'b0;
    end
    check_eq("dwait_dvld", cnt_dvld, 0);
    check_eq("dwait_ivld", cnt_ivld, LW);
    gap = 0;
    do begin
      step(); g++;
      if (!o_d_grant) gap++;
    end while (!o_d_grant && g < 120);
    check_eq("dwait_bubble", gap, 1);
    while (job != JOB_NONE && g < 200) begin step(); g++; end
    check_eq("dwait_timeout", g < 200, 1'b1);
    bus.d_req = 1'b0;
    drain("drain_dwait");

    // Reset in the middle of a D fill; stray returns must not be routed.
    clear_inputs();
    reset_counts();
    bus.d_req = 1'b1; bus.d_addr = 16'h0600;
    g = 0;
    while (cnt_dvld < 3 && g < 50) begin step(); g++; end
    check_eq("rstfill_timeout", g < 50, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.d_req = 1'b0;
    step();
    check_eq("rst_mem_en", o_mem_en, 1'b0);
    check_eq("rst_mem_wr", o_mem_wr, 1'b0);
    check_eq("rst_mem_addr", o_mem_addr, 16'h0);
    check_eq("rst_mem_wdata", o_mem_wdata, 16'h0);
    check_eq("rst_grants", {o_i_grant, o_d_grant}, 2'b00);
    check_eq("rst_valids", {o_ivld, o_dvld, o_wr_done}, 3'b000);
    reset_counts();
    repeat (10) step();
    check_eq("rst_stray_routed", cnt_ivld + cnt_dvld, 0);
    drain("drain_rst");

    // Spurious return while idle.
    clear_inputs();
    reset_counts();
    spurious = 1'b1;
    repeat (3) step();
    spurious = 1'b0;
    check_eq("spurious_routed", cnt_ivld + cnt_dvld + cnt_rd, 0);

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) bus.i_req = ~bus.i_req;
      if ($urandom_range(0, 3) == 0) bus.d_req = ~bus.d_req;
      bus.d_wrt   = ($urandom_range(0, 9) == 0);
      bus.i_addr  = 16'($urandom);
      bus.d_addr  = 16'($urandom);
      bus.d_wdata = 16'($urandom);
      spurious    = ($urandom_range(0, 24) == 0);
      step();
    end
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, cycles from read issue to mem_data_vld (bench use only; RTL latency-agnostic).
REQ-002 SHALL have parameter LINE_WORDS, default 8, words per cache-line fill.
REQ-003 SHALL have ports clk in 1 (single clock; all state on posedge) and rst in 1 (synchronous, active-high).
REQ-004 SHALL have ports i_req in 1 (I-cache fill read request), i_addr in 16 (I-cache word address).
REQ-005 SHALL have ports d_req in 1 (D-cache fill read request), d_addr in 16 (D-cache address), d_wrt in 1 (D-cache write-through request), d_wdata in 16 (store data).
REQ-006 SHALL have ports mem_data in 16 (memory read data) and mem_data_vld in 1 (read data valid).
REQ-007 SHALL have ports mem_en out 1, mem_wr out 1, mem_addr out 16, mem_wdata out 16 (memory command).
REQ-008 SHALL have ports i_grant out 1, d_grant out 1 (owner of memory), i_data_vld out 1, d_data_vld out 1 (routed valid), rdata out 16 (= mem_data), d_wr_done out 1 (store accepted pulse).

Function
REQ-009 SHALL implement FSM states IDLE, I_FILL, D_FILL, D_WRITE.
REQ-010 IDLE: priority d_wrt > d_req > i_req; if d_req and i_req both high, SHALL alternate using a last-fill-owner bit (initially I owner, so D wins first tie).
REQ-011 IDLE with d_wrt: next state D_WRITE; d_wrt beats a simultaneous d_req.
REQ-012 D_WRITE (one cycle): mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_grant=1, d_wr_done=1; next IDLE.
REQ-013 Grants SHALL be registered: request sampled in IDLE, grant high from the next cycle; i_grant and d_grant never both high.
REQ-014 In a FILL state, mem_en SHALL equal owner req AND issue_cnt < LINE_WORDS; mem_wr=0; mem_addr=owner address.
REQ-015 issue_cnt SHALL increment on each forwarded read, saturating at LINE_WORDS; extra owner requests are not forwarded.
REQ-016 ret_cnt SHALL increment on each mem_data_vld in a FILL state; the LINE_WORDS-th beat SHALL return FSM to IDLE next cycle and clear both counters.
REQ-017 i_data_vld = mem_data_vld AND state==I_FILL; d_data_vld = mem_data_vld AND state==D_FILL; combinational, zero latency.
REQ-018 mem_data_vld in IDLE or D_WRITE SHALL be ignored (no routed valid, no counter change).
REQ-019 Owner req deasserting mid-fill SHALL NOT release the grant; release only on ret_cnt reaching LINE_WORDS.
REQ-020 Fill completion and a new request in the same cycle: new request sampled in IDLE on the following cycle (one idle bubble).
REQ-021 Outside D_WRITE mem_wdata SHALL be 0; in IDLE mem_en=0, mem_addr=0.
REQ-022 Counters SHALL be clog2(LINE_WORDS)+1 bits wide; no wrap permitted.

Reset
REQ-023 On rst: state IDLE, counters 0, owner bit = I, all outputs 0 from the next edge, including mid-fill; in-flight returns thereafter are ignored per REQ-018.

Structure
REQ-024 State encoding and LINE_WORDS default SHALL live in shared package mem_pkg, reused by the cache fill FSMs.
REQ-025 Single module; one sub-module natural: arb_counter (saturating up-counter with clear), instantiated for issue_cnt and ret_cnt.
REQ-026 Target 150-250 lines RTL; no latches; all outputs driven in every state.

Verification
REQ-027 d_wrt=1, d_addr=16'h0040, d_wdata=16'hBEEF from IDLE -> next cycle mem_en=1, mem_wr=1, mem_addr=16'h0040, d_wr_done=1; IDLE after.
REQ-028 i_req held, i_addr 16'h0100..16'h010E step 2, MEM_LATENCY=4 -> exactly 8 mem_en reads, 8 i_data_vld pulses, i_grant drops cycle after 8th valid.
REQ-029 i_req and d_req rise together twice in succession -> first fill granted to D, second to I; grants never overlap.
REQ-030 d_req during I_FILL -> d_grant stays 0 until I fill's 8th valid, then D granted after one IDLE cycle; no d_data_vld during I fill.
REQ-031 rst asserted after 3rd valid of D fill -> next cycle all outputs 0, state IDLE; remaining 5 stray mem_data_vld produce no routed valid.
REQ-032 Owner holds req for 12 cycles in fill -> only 8 reads forwarded; spurious mem_data_vld in IDLE -> no output response.
